if_id_reg: RTL and testbench

//   IF/ID pipeline register for the 5-stage MIPS core. Captures the fetched PC and instruction

---
 rtl/mips_defs_pkg.sv | 61 ++++++
 rtl/if_id_reg_if.sv | 39 +++
 rtl/ifid_fetch_check.sv | 27 ++
 rtl/if_id_reg.sv | 96 +++++++++
 tb/tb_if_id_reg.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/mips_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_defs_pkg
//  Description : Shared definitions for the 5-stage MIPS core front end:
//                CP0 exception codes, text-segment bounds, bubble word and
//                the IF/ID slot record with helpers to build bubbles and to
//                test fetch-address legality.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_defs_pkg;

    // CP0 ExcCode values used by the fetch stage
    localparam logic [4:0]  EXC_NONE      = 5'd0;
    localparam logic [4:0]  EXC_ADEL      = 5'd4;

    // Default text segment and the word used for bubbles / faulted fetches
    localparam logic [31:0] DEF_TEXT_BASE = 32'h0000_3000;
    localparam logic [31:0] DEF_TEXT_END  = 32'h0000_4FFC;
    localparam logic [31:0] DEF_NOP_WORD  = 32'h0000_0000;

    // Exception entry point, consumed by the PC-select logic upstream
    localparam logic [31:0] EXC_VECTOR    = 32'h0000_4180;

    // What the IF/ID register bank does on a given edge, in priority order
    typedef enum logic [1:0] {
        ACT_RESET = 2'd0,
        ACT_FLUSH = 2'd1,
        ACT_HOLD  = 2'd2,
        ACT_LOAD  = 2'd3
    } ifid_action_e;

    // Contents of the IF/ID register
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        bd;
        logic        exc;
    } id_slot_t;

    // An empty slot that still remembers a PC (zero for reset/flush)
    function automatic id_slot_t bubble_slot(input logic [31:0] pc,
                                             input logic [31:0] nop_word);
        id_slot_t s;
        s.pc    = pc;
        s.instr = nop_word;
        s.valid = 1'b0;
        s.bd    = 1'b0;
        s.exc   = 1'b0;
        return s;
    endfunction

    // Misaligned or outside [base, top] (top inclusive)
    function automatic logic fetch_addr_bad(input logic [31:0] pc,
                                            input logic [31:0] base,
                                            input logic [31:0] top);
        return (pc[1:0] != 2'b00) || (pc < base) || (pc > top);
    endfunction

endpackage : mips_defs_pkg
`default_nettype wire

// File: rtl/if_id_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg_if
//  Description : Signal bundle between fetch/hazard/decode logic and the
//                IF/ID pipeline register. The master modport is the
//                surrounding pipeline; the slave modport is the register.
//  Revision    : 1.0  initial release
// ============================================================================
interface if_id_reg_if;

    // Fetch side and pipeline control
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        id_stall;
    logic        flush;
    logic        id_is_jump;

    // Decode side
    logic [31:0] id_pc;
    logic [31:0] id_pc8;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        id_bd;
    logic        id_exc;
    logic [4:0]  id_exccode;

    modport master (
        output if_pc, if_instr, if_valid, id_stall, flush, id_is_jump,
        input  id_pc, id_pc8, id_instr, id_valid, id_bd, id_exc, id_exccode
    );

    modport slave (
        input  if_pc, if_instr, if_valid, id_stall, flush, id_is_jump,
        output id_pc, id_pc8, id_instr, id_valid, id_bd, id_exc, id_exccode
    );

endinterface : if_id_reg_if
`default_nettype wire

// File: rtl/ifid_fetch_check.sv
`default_nettype none
// ============================================================================
//  Module      : ifid_fetch_check
//  Description : Combinational fetch-address check. Flags a PC that is not
//                word aligned or lies outside [TEXT_BASE, TEXT_END].
//                Only present when IFID_FETCH_CHECK_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`ifdef IFID_FETCH_CHECK_EN
module ifid_fetch_check
    import mips_defs_pkg::*;
#(
    parameter logic [31:0] TEXT_BASE = DEF_TEXT_BASE,
    parameter logic [31:0] TEXT_END  = DEF_TEXT_END
) (
    input  wire logic [31:0] i_pc,
    output logic             o_fault
);

    // Pure address decode, no state
    always_comb begin
        o_fault = fetch_addr_bad(i_pc, TEXT_BASE, TEXT_END);
    end

endmodule : ifid_fetch_check
`endif
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : IF/ID pipeline register. Captures fetched PC/instruction,
//                supports stall (hold) and flush (bubble), tags delay-slot
//                instructions and carries an AdEL fetch exception.
//                Optional build macro: IFID_FETCH_CHECK_EN enables the
//                fetch-address check; without it id_exc/id_exccode are 0.
//                Reset is synchronous and active low (rst = 0 resets).
//  Revision    : 1.0  initial release
// ============================================================================
module if_id_reg
    import mips_defs_pkg::*;
#(
    parameter logic [31:0] TEXT_BASE = DEF_TEXT_BASE,
    parameter logic [31:0] TEXT_END  = DEF_TEXT_END,
    parameter logic [31:0] NOP_WORD  = DEF_NOP_WORD
) (
    input  wire logic   clk,
    input  wire logic   rst,
    if_id_reg_if.slave  bus
);

    id_slot_t     r_slot;
    id_slot_t     w_load_slot;
    ifid_action_e w_action;
    logic         w_fault;

`ifdef IFID_FETCH_CHECK_EN
    logic w_addr_bad;

    ifid_fetch_check #(
        .TEXT_BASE (TEXT_BASE),
        .TEXT_END  (TEXT_END)
    ) u_fetch_check (
        .i_pc    (bus.if_pc),
        .o_fault (w_addr_bad)
    );

    // Only a real fetch can fault; an empty slot is just a bubble
    assign w_fault = w_addr_bad & bus.if_valid;
`else
    logic [63:0] w_unused_text_bounds;

    assign w_fault              = 1'b0;
    assign w_unused_text_bounds = {TEXT_BASE, TEXT_END};
`endif

    // Edge action in priority order: reset > flush > stall > load
    always_comb begin
        w_action = ACT_LOAD;
        if (!rst) begin
            w_action = ACT_RESET;
        end else if (bus.flush) begin
            w_action = ACT_FLUSH;
        end else if (bus.id_stall) begin
            w_action = ACT_HOLD;
        end
    end

    // Next slot contents for a load; id_bd uses the pre-update valid bit so
    // the word behind a branch/jump in ID gets marked as its delay slot
    always_comb begin
        w_load_slot = bubble_slot(bus.if_pc, NOP_WORD);
        if (bus.if_valid) begin
            w_load_slot.valid = 1'b1;
            w_load_slot.bd    = bus.id_is_jump & r_slot.valid;
            if (w_fault) begin
                // Keep the bad PC for EPC, but never decode the fetched word
                w_load_slot.exc = 1'b1;
            end else begin
                w_load_slot.instr = bus.if_instr;
            end
        end
    end

    // Register bank
    always_ff @(posedge clk) begin
        case (w_action)
            ACT_RESET: r_slot <= bubble_slot(32'h0000_0000, NOP_WORD);
            ACT_FLUSH: r_slot <= bubble_slot(32'h0000_0000, NOP_WORD);
            ACT_HOLD:  r_slot <= r_slot;
            default:   r_slot <= w_load_slot;
        endcase
    end

    assign bus.id_pc      = r_slot.pc;
    assign bus.id_pc8     = r_slot.pc + 32'd8;
    assign bus.id_instr   = r_slot.instr;
    assign bus.id_valid   = r_slot.valid;
    assign bus.id_bd      = r_slot.bd;
    assign bus.id_exc     = r_slot.exc;
    assign bus.id_exccode = r_slot.exc ? EXC_ADEL : EXC_NONE;

endmodule : if_id_reg
`default_nettype wire

// File: tb/tb_if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_reg
//  Description : Self-checking bench for if_id_reg. Directed vectors push
//                hand-computed expectations into a scoreboard queue; a
//                monitor pops one entry per clock and compares the outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_id_reg;

`ifdef IFID_FETCH_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic [31:0] instr;
        logic        valid;
        logic        bd;
        logic        exc;
        logic [4:0]  exccode;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int          checks;
    int          failures;
    exp_t        sb[$];

    if_id_reg_if bus();

    if_id_reg dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, exp);
        end
    endtask

    // Monitor: the register updates every edge, so one expectation per edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            cmp(e.name, "id_pc",      bus.id_pc,              e.pc);
            cmp(e.name, "id_pc8",     bus.id_pc8,             e.pc8);
            cmp(e.name, "id_instr",   bus.id_instr,           e.instr);
            cmp(e.name, "id_valid",   {31'd0, bus.id_valid},  {31'd0, e.valid});
            cmp(e.name, "id_bd",      {31'd0, bus.id_bd},     {31'd0, e.bd});
            cmp(e.name, "id_exc",     {31'd0, bus.id_exc},    {31'd0, e.exc});
            cmp(e.name, "id_exccode", {27'd0, bus.id_exccode},{27'd0, e.exccode});
        end
    end

    // Drive one edge's inputs and queue what ID must show after that edge
    task automatic step(input string nm, input logic r,
                        input logic [31:0] pc, input logic [31:0] ins,
                        input logic v, input logic st, input logic fl, input logic j,
                        input logic [31:0] e_pc, input logic [31:0] e_ins,
                        input logic e_v, input logic e_bd, input logic e_exc,
                        input logic [31:0] e_pc8);
        exp_t e;
        @(negedge clk);
        rst_n          = r;
        bus.if_pc      = pc;
        bus.if_instr   = ins;
        bus.if_valid   = v;
        bus.id_stall   = st;
        bus.flush      = fl;
        bus.id_is_jump = j;
        e.name    = nm;
        e.pc      = e_pc;
        e.pc8     = e_pc8;
        e.instr   = e_ins;
        e.valid   = e_v;
        e.bd      = e_bd;
        e.exc     = e_exc;
        e.exccode = e_exc ? 5'd4 : 5'd0;
        sb.push_back(e);
        @(posedge clk);
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        bus.if_pc      = 32'h3000;
        bus.if_instr   = 32'h2008_0001;
        bus.if_valid   = 1'b1;
        bus.id_stall   = 1'b0;
        bus.flush      = 1'b0;
        bus.id_is_jump = 1'b0;

        // Reset for two edges, then first load
        step("rst0",  0, 32'h3000, 32'h2008_0001, 1, 0, 0, 0, 32'h0,    32'h0,         0, 0, 0, 32'h8);
        step("rst1",  0, 32'h3000, 32'h2008_0001, 1, 0, 0, 0, 32'h0,    32'h0,         0, 0, 0, 32'h8);
        step("ld3000",1, 32'h3000, 32'h2008_0001, 1, 0, 0, 0, 32'h3000, 32'h2008_0001, 1, 0, 0, 32'h3008);

        // Stall holds, then the stalled word and the next load
        step("stall", 1, 32'h3004, 32'h2009_0002, 1, 1, 0, 0, 32'h3000, 32'h2008_0001, 1, 0, 0, 32'h3008);
        step("ld3004",1, 32'h3004, 32'h2009_0002, 1, 0, 0, 0, 32'h3004, 32'h2009_0002, 1, 0, 0, 32'h300C);
        step("ld3008",1, 32'h3008, 32'h200A_0003, 1, 0, 0, 0, 32'h3008, 32'h200A_0003, 1, 0, 0, 32'h3010);

        // beq at 300C; its delay slot 3010 is marked, 3014 is not
        step("beq",   1, 32'h300C, 32'h1000_0003, 1, 0, 0, 0, 32'h300C, 32'h1000_0003, 1, 0, 0, 32'h3014);
        step("ds3010",1, 32'h3010, 32'h200B_0004, 1, 0, 0, 1, 32'h3010, 32'h200B_0004, 1, 1, 0, 32'h3018);
        step("nx3014",1, 32'h3014, 32'h200C_0005, 1, 0, 0, 0, 32'h3014, 32'h200C_0005, 1, 0, 0, 32'h301C);

        // Same with a 3-cycle stall between branch and delay slot
        step("beq2",  1, 32'h3018, 32'h1000_0004, 1, 0, 0, 0, 32'h3018, 32'h1000_0004, 1, 0, 0, 32'h3020);
        step("st2a",  1, 32'h301C, 32'h200D_0006, 1, 1, 0, 1, 32'h3018, 32'h1000_0004, 1, 0, 0, 32'h3020);
        step("st2b",  1, 32'h301C, 32'h200D_0006, 1, 1, 0, 1, 32'h3018, 32'h1000_0004, 1, 0, 0, 32'h3020);
        step("st2c",  1, 32'h301C, 32'h200D_0006, 1, 1, 0, 1, 32'h3018, 32'h1000_0004, 1, 0, 0, 32'h3020);
        step("ds301C",1, 32'h301C, 32'h200D_0006, 1, 0, 0, 1, 32'h301C, 32'h200D_0006, 1, 1, 0, 32'h3024);
        step("nx3020",1, 32'h3020, 32'h200E_0007, 1, 0, 0, 0, 32'h3020, 32'h200E_0007, 1, 0, 0, 32'h3028);

        // Flush wins over stall
        step("flush", 1, 32'h3024, 32'h200F_0008, 1, 1, 1, 1, 32'h0,    32'h0,         0, 0, 0, 32'h8);

        // Empty fetch slot: bubble that keeps the PC; no delay-slot mark after it
        step("inval", 1, 32'h3028, 32'h2010_0009, 0, 0, 0, 0, 32'h3028, 32'h0,         0, 0, 0, 32'h3030);
        step("afterbub",1,32'h302C, 32'h2011_000A, 1, 0, 0, 1, 32'h302C, 32'h2011_000A, 1, 0, 0, 32'h3034);

        // Fetch-address check (faults only when the check is built in)
        step("mis3002",1, 32'h3002, 32'h2012_000B, 1, 0, 0, 0, 32'h3002, CHK ? 32'h0 : 32'h2012_000B, 1, 0, CHK, 32'h300A);
        step("hi5000", 1, 32'h5000, 32'h2013_000C, 1, 0, 0, 0, 32'h5000, CHK ? 32'h0 : 32'h2013_000C, 1, 0, CHK, 32'h5008);
        step("top4FFC",1, 32'h4FFC, 32'h2014_000D, 1, 0, 0, 0, 32'h4FFC, 32'h2014_000D,              1, 0, 0,   32'h5004);
        step("lo2FFC", 1, 32'h2FFC, 32'h2015_000E, 1, 0, 0, 0, 32'h2FFC, CHK ? 32'h0 : 32'h2015_000E, 1, 0, CHK, 32'h3004);

        // Link value wraps modulo 2^32
        step("wrap",   1, 32'hFFFF_FFFC, 32'h2016_000F, 1, 0, 0, 0, 32'hFFFF_FFFC, CHK ? 32'h0 : 32'h2016_000F, 1, 0, CHK, 32'h4);

        // Reset asserted in the middle of a stall
        step("ld3020b",1, 32'h3020, 32'h2017_0010, 1, 0, 0, 0, 32'h3020, 32'h2017_0010, 1, 0, 0, 32'h3028);
        step("rststall",0,32'h3024, 32'h2018_0011, 1, 1, 0, 1, 32'h0,    32'h0,         0, 0, 0, 32'h8);
        step("relrst", 1, 32'h3024, 32'h2018_0011, 1, 0, 0, 0, 32'h3024, 32'h2018_0011, 1, 0, 0, 32'h302C);

        // Drain the scoreboard with a bounded wait
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_if_id_reg
`default_nettype wire
